buffer_command_input: RTL
=========================

# buffer_command_input

Board-facing front end that sits directly upstream of the associative buffer and drives its `ctrl`, `key`, `data_in` and `sw7` inputs. It synchronises and debounces raw push buttons and the mode switch, and turns each clean button press into exactly one single-cycle command. It also presents a key/data snapshot that is stable while the command is issued. This stops a held button from repeating LOAD/INCR/CLR every clock.

## Interface
- `KEY_SIZE`, 4, key width.
- `DATA_SIZE`, 4, data width.
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles required to accept a level change (≥2; bench uses 4).
- `clk  in  1  system clock`
- `async_nreset  in  1  reset, asynchronous, active-low`
- `raw_btn_n  in  3  raw push buttons, active-low; [0]=LOAD, [1]=INCR, [2]=CLR`
- `raw_sw7  in  1  raw mode switch (1 = timer/display mode)`
- `raw_key  in  KEY_SIZE  raw key switches`
- `raw_data  in  DATA_SIZE  raw data switches`
- `ctrl  out  2  command to buffer: NONE=0, LOAD=1, INCR=2, CLR=3`
- `key  out  KEY_SIZE  key snapshot accompanying ctrl`
- `data_in  out  DATA_SIZE  data snapshot accompanying ctrl`
- `sw7  out  1  debounced mode switch`
- `cmd_count  out  8  number of commands issued, wraps 255→0`

## Operation
- All raw inputs pass through 2-flop synchronisers. Button sync flops reset to released (1). Switch sync flops reset to 0.
- `raw_btn_n` and `raw_sw7` are debounced. Switches `raw_key` and `raw_data` are synchronised only.
- Debounce rule, per signal:
  - If the synced value equals the debounced value, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals `DEBOUNCE_CYCLES-1` and a mismatch is still present, the debounced value takes the synced value and the counter clears.
  - A bounce shorter than `DEBOUNCE_CYCLES` cycles never changes the debounced value.
- Press event = debounced button goes from released to pressed. A release generates nothing.
- Command issue: on a press event with debounced `sw7` = 0, register `ctrl` to the matching code for one cycle.
  - In the same cycle, register `key`/`data_in` from the synced switches and increment `cmd_count`.
- Simultaneous press events in one cycle: issue only the highest priority, CLR > INCR > LOAD. The others are dropped, not queued.
- Press event while debounced `sw7` = 1: dropped permanently, no later issue.
- `key`/`data_in` hold their last snapshot between commands.
- `sw7` output = debounced switch, passed straight through.

## Timing
- Reset values: `ctrl` = NONE, `key` = 0, `data_in` = 0, `sw7` = 0, `cmd_count` = 0. All debounce counters 0, debounced buttons released.
- Raw button falls before edge 1 and stays low: synced after edge 2, debounced after edge `DEBOUNCE_CYCLES+2`, `ctrl` ≠ NONE after edge `DEBOUNCE_CYCLES+3`, back to NONE after edge `DEBOUNCE_CYCLES+4`.
- `sw7` changes after edge `DEBOUNCE_CYCLES+2` relative to a stable raw change.
- Key/data snapshot reflects switch values synced 2 edges earlier. It is valid in the same cycle `ctrl` is non-NONE.
- `ctrl` is never non-NONE in two consecutive cycles.
- A button held through reset release yields one press after `DEBOUNCE_CYCLES+3` edges.
- Reset asserted mid-debounce or mid-pulse: everything returns immediately to reset values and no pending command survives.

## Structure
- Shared package: ctrl encodings NONE/LOAD/INCR/CLR, shared with the buffer and the register block, and button index constants.
- Sub-module `debouncer`: parameters `WIDTH` and `CYCLES`, ports `clk`, `async_nreset`, `in`, `out`; includes the synchroniser. Instantiate 4× (3 buttons, sw7). `raw_key` and `raw_data` use synchroniser flops only.
- Counter width = `$clog2(DEBOUNCE_CYCLES)`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Reset, then hold `raw_btn_n`[0] low with `raw_key` = 4'h5, `raw_data` = 4'hA -> `ctrl` = 1 for exactly 1 cycle after edge 7, `key` = 5, `data_in` = A, `cmd_count` = 1; no further pulse while held.
- Toggle `raw_btn_n`[1] with glitches of 1–3 cycles, then hold low 10 cycles -> exactly one `ctrl` = 2.
- Press all three buttons simultaneously -> single `ctrl` = 3, `cmd_count` +1 only.
- Set `raw_sw7` = 1, wait 7 edges (`sw7` = 1), press LOAD -> `ctrl` stays 0. Clear `sw7` -> still no pulse until a new press.
- Issue 256 presses -> `cmd_count` wraps to 0.
- Assert `async_nreset` low during the debounce count, release -> all outputs 0, no pulse until a fresh stable press plus 7 edges.

Source files
------------

// File: rtl/buffer_command_input_pkg.sv
// Shared definitions for the board-facing command front end and its consumers:
// buffer command encodings and push-button indices.
package buffer_command_input_pkg;

  typedef enum logic [1:0] {
    CTRL_NONE = 2'd0,
    CTRL_LOAD = 2'd1,
    CTRL_INCR = 2'd2,
    CTRL_CLR  = 2'd3
  } ctrl_e;

  localparam int NUM_BTN  = 3;
  localparam int BTN_LOAD = 0;
  localparam int BTN_INCR = 1;
  localparam int BTN_CLR  = 2;

  // Simultaneous presses collapse to the single most destructive command.
  function automatic ctrl_e select_cmd(input logic [NUM_BTN-1:0] press);
    if (press[BTN_CLR]) begin
      return CTRL_CLR;
    end else if (press[BTN_INCR]) begin
      return CTRL_INCR;
    end else if (press[BTN_LOAD]) begin
      return CTRL_LOAD;
    end
    return CTRL_NONE;
  endfunction

endpackage

// File: rtl/buffer_command_input_if.sv
// Raw board inputs plus the command bundle handed to the associative buffer.
interface buffer_command_input_if #(
  parameter int KEY_SIZE  = 4,
  parameter int DATA_SIZE = 4
) ();
  logic [2:0]           raw_btn_n;
  logic                 raw_sw7;
  logic [KEY_SIZE-1:0]  raw_key;
  logic [DATA_SIZE-1:0] raw_data;
  logic [1:0]           ctrl;
  logic [KEY_SIZE-1:0]  key;
  logic [DATA_SIZE-1:0] data_in;
  logic                 sw7;
  logic [7:0]           cmd_count;

  modport master (
    input  raw_btn_n, raw_sw7, raw_key, raw_data,
    output ctrl, key, data_in, sw7, cmd_count
  );

  modport slave (
    output raw_btn_n, raw_sw7, raw_key, raw_data,
    input  ctrl, key, data_in, sw7, cmd_count
  );
endinterface

// File: rtl/buffer_command_input_debouncer.sv
// Two-flop synchroniser followed by a per-bit stability counter; a level change
// is accepted only after it has been seen for CYCLES consecutive clocks.
module debouncer #(
  parameter int               WIDTH   = 1,
  parameter int               CYCLES  = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             async_nreset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  localparam int               CNT_W    = $clog2(CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [CNT_W-1:0] cnt [WIDTH];

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
      out     <= RST_VAL;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync_p0 <= in;
      sync_p1 <= sync_p0;
      // Stage boundary: synchronised level vs. accepted level.
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_p1[i] == out[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          out[i] <= sync_p1[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/buffer_command_input.sv
// Turns debounced button presses into single-cycle buffer commands with a
// key/data snapshot, gated by the debounced mode switch.
module buffer_command_input
  import buffer_command_input_pkg::*;
#(
  parameter int KEY_SIZE        = 4,
  parameter int DATA_SIZE       = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic              clk,
  input logic              async_nreset,
  buffer_command_input_if.master bus
);

  logic [NUM_BTN-1:0]   btn_deb;
  logic [NUM_BTN-1:0]   btn_prev;
  logic [NUM_BTN-1:0]   press;
  logic                 sw7_deb;
  logic [KEY_SIZE-1:0]  key_p0, key_p1;
  logic [DATA_SIZE-1:0] data_p0, data_p1;
  logic [1:0]           ctrl_q;
  logic [KEY_SIZE-1:0]  key_q;
  logic [DATA_SIZE-1:0] data_q;
  logic [7:0]           count_q;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    debouncer #(
      .WIDTH   (1),
      .CYCLES  (DEBOUNCE_CYCLES),
      .RST_VAL (1'b1)
    ) u_btn (
      .clk          (clk),
      .async_nreset (async_nreset),
      .in           (bus.raw_btn_n[g]),
      .out          (btn_deb[g])
    );
  end

  debouncer #(
    .WIDTH   (1),
    .CYCLES  (DEBOUNCE_CYCLES),
    .RST_VAL (1'b0)
  ) u_sw7 (
    .clk          (clk),
    .async_nreset (async_nreset),
    .in           (bus.raw_sw7),
    .out          (sw7_deb)
  );

  // Active-low buttons: a press is a released-to-pressed edge of the debounced level.
  assign press = btn_prev & ~btn_deb;

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      key_p0   <= '0;
      key_p1   <= '0;
      data_p0  <= '0;
      data_p1  <= '0;
      btn_prev <= '1;
      ctrl_q   <= CTRL_NONE;
      key_q    <= '0;
      data_q   <= '0;
      count_q  <= '0;
    end else begin
      key_p0   <= bus.raw_key;
      key_p1   <= key_p0;
      data_p0  <= bus.raw_data;
      data_p1  <= data_p0;
      btn_prev <= btn_deb;
      // Stage boundary: command issue; presses in display mode are discarded.
      if ((press != '0) && !sw7_deb) begin
        ctrl_q  <= select_cmd(press);
        key_q   <= key_p1;
        data_q  <= data_p1;
        count_q <= count_q + 8'd1;
      end else begin
        ctrl_q  <= CTRL_NONE;
      end
    end
  end

  assign bus.ctrl      = ctrl_q;
  assign bus.key       = key_q;
  assign bus.data_in   = data_q;
  assign bus.sw7       = sw7_deb;
  assign bus.cmd_count = count_q;

endmodule
